// File: rtl/gray_ptr_pkg.sv
// gray_ptr_pkg
// Shared helpers for the Gray-coded pointer crossing blocks.
// Functions operate on a fixed MAX_W-bit container; callers zero-extend
// narrower pointers on the way in and truncate on the way out. Zero
// extension is harmless for both conversions because the extra upper bits
// stay zero.
//   bin2gray     : binary -> Gray
//   gray2bin     : Gray -> binary
//   popcount_gt1 : true when more than one bit of the argument is set
package gray_ptr_pkg;

  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and all Gray bits above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Clearing the lowest set bit leaves something nonzero only if at least
  // two bits were set.
  function automatic logic popcount_gt1(input ptr_t x);
    return (x & (x - ptr_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
// Brings a remote Gray pointer into the local clock domain, decodes it to
// binary and flags any synchronised step that changed more than one bit.
// Ports:
//   CLK  : local clock
//   RST  : asynchronous active-high reset
//   G_IN : remote Gray pointer, asynchronous to CLK
//   RB   : registered binary decode of the synchronised pointer
//   HOP  : sticky flag, set when two consecutive synchronised values
//          differ in more than one bit; cleared only by RST
module gray_ptr_sync
  import gray_ptr_pkg::*;
#(
  parameter int               width = 4,
  parameter logic [width-1:0] init  = {width{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] G_IN,
  output logic [width-1:0] RB,
  output logic             HOP
);

  localparam logic [width-1:0] INIT_G = width'(bin2gray(ptr_t'(init)));

  logic [width-1:0] s1;
  logic [width-1:0] s2;
  logic [width-1:0] s3;
  logic [width-1:0] rb_q;
  logic             hop_q;

  // s1/s2 form the metastability chain; s3 only holds the previous s2 so a
  // multi-bit jump between successive settled samples can be detected.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1    <= INIT_G;
      s2    <= INIT_G;
      s3    <= INIT_G;
      rb_q  <= init;
      hop_q <= 1'b0;
    end else begin
      s1   <= G_IN;
      s2   <= s1;
      s3   <= s2;
      rb_q <= width'(gray2bin(ptr_t'(s2)));
      if (popcount_gt1(ptr_t'(s2 ^ s3))) begin
        hop_q <= 1'b1;
      end
    end
  end

  assign RB  = rb_q;
  assign HOP = hop_q;

endmodule

// File: rtl/gray_ptr_rx.sv
// gray_ptr_rx
// Read-side pointer block of an asynchronous FIFO. Synchronises the
// write-side Gray pointer, keeps the local binary/Gray read pointer and
// derives occupancy, empty and underflow.
// Ports:
//   CLK     : local clock
//   RST     : asynchronous active-high reset
//   G_IN    : remote Gray pointer from the write domain
//   DEQ     : request to advance the local pointer
//   B_OUT   : local binary pointer
//   G_OUT   : local Gray pointer, returned to the write domain
//   RB_OUT  : decoded remote binary pointer
//   COUNT   : occupancy, RB_OUT - B_OUT modulo 2^width
//   EMPTY   : COUNT == 0
//   UFLOW   : one-cycle pulse after DEQ was seen while EMPTY
//   HOP_ERR : sticky multi-bit-step error from the synchroniser
module gray_ptr_rx
  import gray_ptr_pkg::*;
#(
  parameter int               width = 4,
  parameter logic [width-1:0] init  = {width{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] G_IN,
  input  logic             DEQ,
  output logic [width-1:0] B_OUT,
  output logic [width-1:0] G_OUT,
  output logic [width-1:0] RB_OUT,
  output logic [width-1:0] COUNT,
  output logic             EMPTY,
  output logic             UFLOW,
  output logic             HOP_ERR
);

  // A one-bit pointer has no room for a wrap bit, so it cannot tell full
  // from empty; refuse to elaborate rather than misbehave.
  if (width < 2 || width > MAX_W) begin : g_bad_width
    $fatal(1, "gray_ptr_rx: parameter width=%0d out of range 2..%0d", width, MAX_W);
  end

  localparam logic [width-1:0] INIT_G = width'(bin2gray(ptr_t'(init)));

  logic [width-1:0] rb;
  logic             hop;
  logic [width-1:0] b_q;
  logic [width-1:0] g_q;
  logic [width-1:0] b_next;
  logic [width-1:0] count;
  logic             empty;
  logic             adv;
  logic             uflow_q;

  gray_ptr_sync #(
    .width (width),
    .init  (init)
  ) u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .G_IN (G_IN),
    .RB   (rb),
    .HOP  (hop)
  );

  // Occupancy wraps naturally because both pointers carry the wrap bit.
  assign count  = rb - b_q;
  assign empty  = (count == '0);
  assign adv    = DEQ & ~empty;
  assign b_next = b_q + width'(1);

  // Binary and Gray copies are loaded from the same b_next so they can
  // never disagree; the Gray copy is registered so it is glitch-free when
  // it crosses back to the write domain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      b_q     <= init;
      g_q     <= INIT_G;
      uflow_q <= 1'b0;
    end else begin
      if (adv) begin
        b_q <= b_next;
        g_q <= width'(bin2gray(ptr_t'(b_next)));
      end
      uflow_q <= DEQ & empty;
    end
  end

  assign B_OUT   = b_q;
  assign G_OUT   = g_q;
  assign RB_OUT  = rb;
  assign COUNT   = count;
  assign EMPTY   = empty;
  assign UFLOW   = uflow_q;
  assign HOP_ERR = hop;

endmodule

// File: doc/gray_ptr_rx.md
# gray_ptr_rx

Receive-side pointer block for a Gray-coded clock-domain crossing. It takes a Gray-coded pointer driven from a counter in another clock domain and synchronises it through two flops. It decodes the synchronised value to binary and keeps a local dual binary/Gray counter that advances on dequeue. From these it derives the occupancy count and the empty flag. It sits on the read side of an asynchronous FIFO, facing the write-side dual counter.

## Interface
- `width`, default 4: pointer width in bits, including the wrap bit; minimum 2.
- `init`, default `{width{1'b0}}`: binary reset value of both the local and the remote pointer.
- `CLK` input, 1 bit: local clock. All state changes on posedge.
- `RST` input, 1 bit: **reset is asynchronous and active-high; one clock.**
- `G_IN` input, `width` bits: remote Gray pointer. Asynchronous to `CLK`; changes by at most one bit per remote step.
- `DEQ` input, 1 bit: request to advance the local pointer.
- `B_OUT` output, `width` bits: local binary pointer.
- `G_OUT` output, `width` bits: local Gray pointer, for return to the remote domain.
- `RB_OUT` output, `width` bits: decoded remote binary pointer.
- `COUNT` output, `width` bits: occupancy, `RB_OUT - B_OUT` mod 2^width.
- `EMPTY` output, 1 bit: high when `COUNT == 0`.
- `UFLOW` output, 1 bit: one-cycle pulse, registered; `DEQ` was high while `EMPTY` was high.
- `HOP_ERR` output, 1 bit: sticky; the synchronised remote Gray value moved by more than one bit.

## Operation
- **Sync chain.** `s1 <= G_IN`, `s2 <= s1`, `s3 <= s2`.
- **Remote decode.** `rb <= gray2bin(s2)`, where `b[w-1] = g[w-1]` and `b[i] = b[i+1] ^ g[i]`.
- **Hop check.** `HOP_ERR` sets when `popcount(s2 ^ s3) > 1`. It clears only on reset.
- **Local counter.**
  - Advances when `DEQ & !EMPTY`: `B <= B + 1`, `G <= (B+1) ^ ((B+1) >> 1)`.
  - Otherwise holds.
  - `B` and `G` always update together and stay consistent.
- **Underflow.** `DEQ & EMPTY` leaves the pointers unchanged and sets `UFLOW <= 1` for the next cycle.
- **Combinational outputs.** `COUNT` and `EMPTY` are combinational from the registered `rb` and `B`. They reflect a dequeue on the same edge at which the pointer moves.
- **Wrap-around.** All arithmetic is modulo 2^width. The pointer wraps from `2^width-1` to 0. `COUNT` stays correct across the wrap. Full is never reported here, since this is the read side.
- **Simultaneous events.** A remote advance and a local dequeue on the same edge are both applied. `COUNT` reflects both.
- **Reset values** (asynchronous, any time, including mid-operation):
  - `B = init`, `G = gray(init)`.
  - `s1`, `s2`, `s3 = gray(init)`, `rb = init`.
  - Outputs: `COUNT = 0`, `EMPTY = 1`, `UFLOW = 0`, `HOP_ERR = 0`.
- No initial blocks are used for functional state. With width < 2, simulation halts with a parameter error.

## Timing
- **Remote-to-output latency.** A `G_IN` change that is stable before edge N appears in `s1` at N and in `s2` at N+1. It appears in `rb`, `RB_OUT`, `COUNT` and `EMPTY` after N+2, so the latency is 3 edges.
- **Local latency.** Dequeue takes effect in `B_OUT`, `G_OUT` and `COUNT` immediately after the edge on which `DEQ` is sampled: 1 cycle.
- **Back-to-back dequeue.** `DEQ` held high drains one entry per cycle until `EMPTY`. The cycle after `EMPTY` rises, any further `DEQ` gives `UFLOW` pulses.
- **Hop error latency.** `HOP_ERR` rises 1 cycle after the offending `s2` value, i.e. 3 edges after the bad `G_IN`.

## Structure
- **Shared package** `gray_ptr_pkg` holds:
  - `function gray2bin`
  - `function bin2gray`
  - `function popcount_gt1`
- **Sub-module** `gray_ptr_sync`, parameter `width`:
  - contains `s1`, `s2`, `s3`, the `rb` decode register and the hop check;
  - ports: `CLK`, `RST`, `G_IN`, `RB`, `HOP`.
- The top level holds the local counter, the `COUNT`/`EMPTY` logic and the `UFLOW` register.

## Test plan
- **Reset.** `width=4`, `init=0`, `RST` high → `B_OUT=0`, `G_OUT=0`, `RB_OUT=0`, `EMPTY=1`, `COUNT=0`, `UFLOW=0`, `HOP_ERR=0`.
- **Remote latency.** `G_IN` stepped 0→1→3 (Gray of 1 and 2) on consecutive edges → `RB_OUT` reaches 1 three edges after the first step, then 2. `COUNT=2`, `EMPTY=0`.
- **Drain and underflow.** With `COUNT=2`, hold `DEQ` for 3 cycles → `B_OUT` goes 1 then 2, `G_OUT` goes 1 then 3. `EMPTY` rises after the second dequeue. `UFLOW` pulses once, and `B_OUT` stays 2.
- **Wrap-around.** Drive `G_IN` through all 16 Gray codes twice while dequeuing every cycle → `B_OUT` wraps 15→0, `COUNT` never exceeds 3, no `UFLOW`, no `HOP_ERR`.
- **Hop error.** `G_IN` jumps 0→3 (two bits change) → `HOP_ERR=1` three edges later and stays 1 until `RST`.
- **Reset mid-operation.** `RST` asserted between edges with `COUNT=5` → all registers and outputs return to reset values immediately, before the next `CLK` edge.
